// File: rtl/twpm_wb_mailbox_if.sv
// Wishbone classic slave bus used by the TPM mailbox.
// The CPU side is the master, the mailbox is the slave.
interface twpm_wb_mailbox_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/twpm_wb_mailbox.sv
// TPM command/response mailbox between the CPU Wishbone bus and the data
// provider: buffer RAM, exec snapshots, complete pulse and CPU interrupt.
module twpm_wb_mailbox #(
    parameter int unsigned RAM_ADDR_WIDTH       = 11,
    parameter logic [16:0] RAM_BASE             = 17'h00800,
    parameter int unsigned COMPLETE_PULSE_WIDTH = 20,
    parameter logic [31:0] DEFAULT_READ_VALUE   = 32'hBADFABAC
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    twpm_wb_mailbox_if.slave          wb,
    input  logic [RAM_ADDR_WIDTH-1:0] dp_addr_i,
    input  logic [7:0]                dp_data_i,
    input  logic                      dp_wr_i,
    input  logic                      dp_rd_i,
    output logic [7:0]                dp_data_o,
    input  logic [3:0]                op_type_i,
    input  logic [3:0]                locality_i,
    input  logic [RAM_ADDR_WIDTH-1:0] buf_len_i,
    input  logic                      exec_i,
    input  logic                      abort_i,
    output logic                      complete_o,
    output logic                      irq_o
);
    localparam int unsigned WA    = RAM_ADDR_WIDTH - 2;
    localparam int unsigned WORDS = 1 << WA;

    logic [31:0] mem [WORDS];
    logic [31:0] ram_q;
    logic [WA-1:0] ram_addr;
    logic [3:0] ram_be;
    logic [31:0] ram_wdata;

    logic exec_q, abort_q;
    logic [3:0] op_q, loc_q;
    logic [RAM_ADDR_WIDTH-1:0] len_q;
    logic [1:0] irq_en;
    logic irq_pend;
    logic [7:0] cnt;
    logic ack_q, err_q, ram_rd_q;
    logic [31:0] dat_q, reg_rdata;
    logic dp_rd_q;
    logic [1:0] dp_lane_q;
    logic [7:0] dp_hold, dp_byte;

    logic req, wr, ram_hit, ram_ok;
    logic [14:0] off;
    logic is_status, is_op, is_loc, is_len, is_en, is_cmp;
    logic exec_rise, abort_rise, irq_set, irq_clr, cmp_go;
    logic unused_adr;

    assign off = wb.wb_adr_i[16:2];
    assign ram_hit = wb.wb_adr_i[16:RAM_ADDR_WIDTH]
                     == RAM_BASE[16:RAM_ADDR_WIDTH];
    // A termination in flight blocks the next request for one cycle.
    assign req = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q & ~err_q;
    assign wr = req & wb.wb_we_i;
    assign ram_ok = ram_hit & exec_i;

    assign is_status = ~ram_hit & (off == 15'h0000);
    assign is_op     = ~ram_hit & (off == 15'h0001);
    assign is_loc    = ~ram_hit & (off == 15'h0002);
    assign is_len    = ~ram_hit & (off == 15'h0003);
    assign is_en     = ~ram_hit & (off == 15'h0004);
    assign is_cmp    = ~ram_hit & (off == 15'h0010);

    assign exec_rise  = exec_i & ~exec_q;
    assign abort_rise = abort_i & ~abort_q;
    assign irq_set = (exec_rise & irq_en[0]) | (abort_rise & irq_en[1]);
    assign irq_clr = wr & is_status & wb.wb_sel_i[0] & wb.wb_dat_i[3];
    assign cmp_go  = wr & is_cmp & exec_i & (cnt == 8'd0);

    assign unused_adr = ^{wb.wb_adr_i[31:17], wb.wb_adr_i[1:0]};

    always_comb begin
        reg_rdata = DEFAULT_READ_VALUE;
        unique case (1'b1)
            is_status: reg_rdata = {28'd0, irq_pend, complete_o,
                                    abort_i, exec_i};
            is_op:     reg_rdata = {28'd0, op_q};
            is_loc:    reg_rdata = {28'd0, loc_q};
            is_len:    reg_rdata = 32'(len_q);
            is_en:     reg_rdata = {30'd0, irq_en};
            is_cmp:    reg_rdata = 32'd0;
            default:   reg_rdata = DEFAULT_READ_VALUE;
        endcase
    end

    // Single RAM port, steered by whoever currently owns the buffer.
    always_comb begin
        ram_addr  = exec_i ? wb.wb_adr_i[RAM_ADDR_WIDTH-1:2]
                           : dp_addr_i[RAM_ADDR_WIDTH-1:2];
        ram_be    = 4'b0000;
        ram_wdata = wb.wb_dat_i;
        if (exec_i) begin
            if (wr && ram_hit)
                ram_be = wb.wb_sel_i;
        end else if (dp_wr_i) begin
            ram_be    = 4'b0001 << dp_addr_i[1:0];
            ram_wdata = {4{dp_data_i}};
        end
    end

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++)
            if (ram_be[b])
                mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        ram_q <= mem[ram_addr];
    end

    assign dp_byte = ram_q[{dp_lane_q, 3'b000} +: 8];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            exec_q    <= 1'b0;
            abort_q   <= 1'b0;
            op_q      <= '0;
            loc_q     <= '0;
            len_q     <= '0;
            irq_en    <= '0;
            irq_pend  <= 1'b0;
            cnt       <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            ram_rd_q  <= 1'b0;
            dat_q     <= '0;
            dp_rd_q   <= 1'b0;
            dp_lane_q <= '0;
            dp_hold   <= 8'hFF;
        end else begin
            exec_q  <= exec_i;
            abort_q <= abort_i;
            if (exec_rise) begin
                op_q  <= op_type_i;
                loc_q <= locality_i;
                len_q <= buf_len_i;
            end
            irq_pend <= irq_set | (irq_pend & ~irq_clr);
            if (wr && is_en && wb.wb_sel_i[0])
                irq_en <= wb.wb_dat_i[1:0];
            if (cmp_go)
                cnt <= 8'(COMPLETE_PULSE_WIDTH);
            else if (cnt != 8'd0)
                cnt <= cnt - 8'd1;
            ack_q    <= req & ~(ram_hit & ~exec_i);
            err_q    <= req & ram_hit & ~exec_i;
            ram_rd_q <= req & ~wb.wb_we_i & ram_ok;
            dat_q    <= (req & ~wb.wb_we_i & ~ram_hit) ? reg_rdata : 32'd0;
            dp_rd_q   <= dp_rd_i & ~exec_i;
            dp_lane_q <= dp_addr_i[1:0];
            // Latest read request wins: a blocked read overrides capture.
            if (dp_rd_q)
                dp_hold <= dp_byte;
            if (dp_rd_i && exec_i)
                dp_hold <= 8'hFF;
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;
    assign wb.wb_dat_o = ram_rd_q ? ram_q : dat_q;
    assign dp_data_o   = dp_rd_q ? dp_byte : dp_hold;
    assign complete_o  = cnt != 8'd0;
    assign irq_o       = irq_pend;
endmodule

// File: tb/tb_twpm_wb_mailbox.sv
// Directed bench for twpm_wb_mailbox with a byte-array/cycle-window model
// compared against the outputs every cycle.
module tb_twpm_wb_mailbox;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [10:0] dp_addr;
    logic [7:0] dp_din, dp_dout;
    logic dp_wr, dp_rd;
    logic [3:0] op_type, locality;
    logic [10:0] buf_len;
    logic exec, abort, complete, irq;

    twpm_wb_mailbox_if bus();

    twpm_wb_mailbox dut (
        .clk_i(clk), .rst_i(rst), .wb(bus),
        .dp_addr_i(dp_addr), .dp_data_i(dp_din),
        .dp_wr_i(dp_wr), .dp_rd_i(dp_rd), .dp_data_o(dp_dout),
        .op_type_i(op_type), .locality_i(locality), .buf_len_i(buf_len),
        .exec_i(exec), .abort_i(abort),
        .complete_o(complete), .irq_o(irq)
    );

    int total = 0, bad = 0;

    logic [7:0] mem_m [2048];
    logic x_ack = 0, x_err = 0, x_rd = 0, x_irq = 0;
    logic [31:0] x_dat = 0;
    logic [7:0] x_dp = 8'hFF;
    logic [3:0] s_op = 0, s_loc = 0;
    logic [10:0] s_len = 0;
    logic [1:0] en_m = 0;
    logic p_exec = 0, p_abort = 0;
    int k = 0, c_first = -100, c_last = -100;
    bit chk_on = 0;
    int hi_cnt = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, k);
        end
    endtask

    // complete_o is high during the 20-cycle window [c_first, c_last]
    function automatic bit active(int c);
        return c >= c_first && c <= c_last;
    endfunction

    function automatic logic [31:0] reg_read(logic [16:0] a);
        case ({a[16:2], 2'b00})
            17'h00000: return {28'd0, x_irq, active(k), abort, exec};
            17'h00004: return {28'd0, s_op};
            17'h00008: return {28'd0, s_loc};
            17'h0000C: return {21'd0, s_len};
            17'h00010: return {30'd0, en_m};
            17'h00040: return 32'd0;
            default:   return 32'hBADFABAC;
        endcase
    endfunction

    task automatic model_edge();
        int n, base;
        logic [16:0] a;
        logic nack, nerr, nrd, clr, set, in_ram;
        logic [31:0] ndat, d;
        logic [1:0] en_n;
        n = k + 1;
        a = bus.wb_adr_i[16:0];
        d = bus.wb_dat_i;
        if (rst) begin
            x_ack = 0; x_err = 0; x_rd = 0; x_irq = 0; x_dp = 8'hFF;
            s_op = 0; s_loc = 0; s_len = 0; en_m = 0;
            p_exec = 0; p_abort = 0; c_first = -100; c_last = -100;
        end else begin
            nack = 0; nerr = 0; nrd = 0; clr = 0; ndat = 0; en_n = en_m;
            in_ram = a >= 17'h00800 && a < 17'h01000;
            base = int'(a[10:2]) * 4;
            if (bus.wb_cyc_i && bus.wb_stb_i && !(x_ack || x_err)) begin
                if (in_ram && !exec) begin
                    nerr = 1;
                end else begin
                    nack = 1;
                    nrd = !bus.wb_we_i;
                    if (in_ram && bus.wb_we_i) begin
                        for (int b = 0; b < 4; b++)
                            if (bus.wb_sel_i[b]) mem_m[base+b] = d[8*b +: 8];
                    end else if (in_ram) begin
                        ndat = {mem_m[base+3], mem_m[base+2],
                                mem_m[base+1], mem_m[base]};
                    end else if (bus.wb_we_i) begin
                        if (a[16:2] == 0 && bus.wb_sel_i[0] && d[3]) clr = 1;
                        if (a[16:2] == 4 && bus.wb_sel_i[0]) en_n = d[1:0];
                        if (a[16:2] == 16 && exec && !active(k)) begin
                            c_first = n;
                            c_last = n + 19;
                        end
                    end else begin
                        ndat = reg_read(a);
                    end
                end
            end
            set = (exec && !p_exec && en_m[0]) || (abort && !p_abort && en_m[1]);
            if (exec && !p_exec) begin
                s_op = op_type; s_loc = locality; s_len = buf_len;
            end
            x_irq = set || (x_irq && !clr);
            en_m = en_n;
            if (dp_rd) x_dp = exec ? 8'hFF : mem_m[dp_addr];
            if (dp_wr && !exec) mem_m[dp_addr] = dp_din;
            p_exec = exec; p_abort = abort;
            x_ack = nack; x_err = nerr; x_rd = nrd; x_dat = ndat;
        end
        k = n;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("ack", bus.wb_ack_o, x_ack);
            check("err", bus.wb_err_o, x_err);
            if ((x_ack && x_rd) || x_err) check("rdata", bus.wb_dat_o, x_dat);
            check("dp_data", dp_dout, x_dp);
            check("irq", irq, x_irq);
            check("complete", complete, active(k));
            if (complete) hi_cnt++;
        end
    end

    task automatic wb(input logic [31:0] a, input logic w,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic ak,
                      output logic er, output int lat);
        bus.wb_adr_i = a; bus.wb_we_i = w; bus.wb_dat_i = d;
        bus.wb_sel_i = s; bus.wb_cyc_i = 1; bus.wb_stb_i = 1;
        lat = 0; ak = 0; er = 0; rd = 0;
        while (lat < 4 && !ak && !er) begin
            tick();
            lat++;
            ak = bus.wb_ack_o; er = bus.wb_err_o; rd = bus.wb_dat_o;
        end
        if (!ak && !er) begin
            total++; bad++;
            $display("FAIL wb_timeout: addr %h got no termination want one", a);
        end
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
    endtask

    task automatic dp_write(input logic [10:0] a, input logic [7:0] d);
        dp_addr = a; dp_din = d; dp_wr = 1;
        tick();
        dp_wr = 0;
    endtask

    task automatic dp_read(input logic [10:0] a, output logic [7:0] d);
        dp_addr = a; dp_rd = 1;
        tick();
        dp_rd = 0;
        d = dp_dout;
    endtask

    logic [31:0] rd;
    logic ak, er;
    int lat;
    logic [7:0] db;
    logic [7:0] exp4 [4];

    initial begin
        rst = 1; dp_addr = 0; dp_din = 0; dp_wr = 0; dp_rd = 0;
        op_type = 0; locality = 0; buf_len = 0; exec = 0; abort = 0;
        bus.wb_adr_i = 0; bus.wb_dat_i = 0; bus.wb_we_i = 0;
        bus.wb_sel_i = 0; bus.wb_stb_i = 0; bus.wb_cyc_i = 0;
        tick();
        chk_on = 1;
        tick(); tick();
        rst = 0;
        check("rst_ack", bus.wb_ack_o, 0);
        check("rst_err", bus.wb_err_o, 0);
        check("rst_dat", bus.wb_dat_o, 0);
        check("rst_complete", complete, 0);
        check("rst_irq", irq, 0);
        check("rst_dp", dp_dout, 8'hFF);

        for (int i = 0; i < 4; i++) dp_write(11'(i), 8'(8'h11 * (i + 1)));
        for (int i = 4; i < 8; i++) dp_write(11'(i), 8'(8'hA0 + i));
        dp_read(11'd2, db);
        check("dp_rd2", db, 8'h33);

        wb(32'h804, 1, 32'hDEADBEEF, 4'b0110, rd, ak, er, lat);
        check("own_err_w", {ak, er}, 2'b01);
        wb(32'h800, 0, 0, 4'hF, rd, ak, er, lat);
        check("own_err_r", {ak, er, rd}, {2'b01, 32'd0});

        exec = 1; op_type = 4'h3; locality = 4'h2; buf_len = 11'd12;
        tick();
        op_type = 4'h9; locality = 4'h5; buf_len = 11'd100;
        wb(32'h800, 0, 0, 4'hF, rd, ak, er, lat);
        check("ram_rd", rd, 32'h44332211);
        check("ram_lat", lat, 1);
        wb(32'h04, 0, 0, 4'hF, rd, ak, er, lat);
        check("op_type", rd, 3);
        wb(32'h08, 0, 0, 4'hF, rd, ak, er, lat);
        check("locality", rd, 2);
        wb(32'h0C, 0, 0, 4'hF, rd, ak, er, lat);
        check("buf_size", rd, 12);

        wb(32'h804, 1, 32'hDEADBEEF, 4'b0110, rd, ak, er, lat);
        check("own_ack_w", {ak, er}, 2'b10);
        dp_read(11'd5, db);
        check("dp_blocked", db, 8'hFF);

        exec = 0;
        tick();
        exp4[0] = 8'hA4; exp4[1] = 8'hBE; exp4[2] = 8'hAD; exp4[3] = 8'hA7;
        for (int i = 0; i < 4; i++) begin
            dp_read(11'(4 + i), db);
            check("dp_lane", db, exp4[i]);
        end

        wb(32'h10, 1, 32'h1, 4'hF, rd, ak, er, lat);
        exec = 1;
        tick();
        check("irq_exec", irq, 1);
        wb(32'h00, 1, 32'h8, 4'hF, rd, ak, er, lat);
        check("irq_w1c", irq, 0);
        exec = 0; tick();
        abort = 1; tick(); abort = 0; tick();
        check("irq_abort_masked", irq, 0);
        exec = 1;
        wb(32'h00, 1, 32'h8, 4'hF, rd, ak, er, lat);
        check("irq_set_wins", irq, 1);
        wb(32'h10, 1, 32'h2, 4'hF, rd, ak, er, lat);
        wb(32'h00, 1, 32'h8, 4'hF, rd, ak, er, lat);
        abort = 1; tick(); abort = 0;
        check("irq_abort", irq, 1);
        wb(32'h00, 1, 32'h8, 4'hF, rd, ak, er, lat);

        hi_cnt = 0;
        wb(32'h40, 1, 32'h1, 4'hF, rd, ak, er, lat);
        repeat (4) tick();
        wb(32'h40, 1, 32'h1, 4'hF, rd, ak, er, lat);
        wb(32'h00, 0, 0, 4'hF, rd, ak, er, lat);
        check("status_cmp", rd[2], 1);
        wb(32'h40, 0, 0, 4'hF, rd, ak, er, lat);
        check("cmp_rd0", rd, 0);
        repeat (30) tick();
        check("cmp_width", hi_cnt, 20);
        exec = 0; tick();
        hi_cnt = 0;
        wb(32'h40, 1, 32'h1, 4'hF, rd, ak, er, lat);
        repeat (25) tick();
        check("cmp_noexec", hi_cnt, 0);

        wb(32'h20, 0, 0, 4'hF, rd, ak, er, lat);
        check("default_rd", {ak, rd}, {1'b1, 32'hBADFABAC});
        wb(32'h20, 1, 32'h0, 4'hF, rd, ak, er, lat);
        check("default_wr", {ak, er}, 2'b10);

        wb(32'h10, 1, 32'h1, 4'hF, rd, ak, er, lat);
        exec = 1; tick();
        wb(32'h40, 1, 32'h1, 4'hF, rd, ak, er, lat);
        bus.wb_adr_i = 32'h0C; bus.wb_we_i = 0;
        bus.wb_cyc_i = 1; bus.wb_stb_i = 1;
        rst = 1; exec = 0;
        tick();
        check("mid_rst_ack", {bus.wb_ack_o, bus.wb_err_o}, 2'b00);
        check("mid_rst_out", {bus.wb_dat_o, irq, complete, dp_dout},
              {32'd0, 1'b0, 1'b0, 8'hFF});
        rst = 0; bus.wb_cyc_i = 0; bus.wb_stb_i = 0;
        tick();
        check("post_rst_ack", bus.wb_ack_o, 0);
        wb(32'h10, 0, 0, 4'hF, rd, ak, er, lat);
        check("post_rst_en", rd, 0);
        wb(32'h04, 0, 0, 4'hF, rd, ak, er, lat);
        check("post_rst_op", rd, 0);
        tick();

        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
